// File: rtl/processor_gen2_pkg.sv
// processor_gen2 shared definitions
// opcode, memory-request, cpu-state and error encodings
package processor_gen2_pkg;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_SET = 3'd1;
    localparam logic [2:0] OP_GET = 3'd2;
    localparam logic [2:0] OP_LD  = 3'd3;
    localparam logic [2:0] OP_ST  = 3'd4;
    localparam logic [2:0] OP_ADD = 3'd5;
    localparam logic [2:0] OP_JMP = 3'd6;
    localparam logic [2:0] OP_ILL = 3'd7;

    localparam logic [1:0] IO_IDLE = 2'd0;
    localparam logic [1:0] IO_RD   = 2'd1;
    localparam logic [1:0] IO_WT   = 2'd2;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXE   = 2'd1;
    localparam logic [1:0] S_MEM   = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op != OP_ILL;
    endfunction

endpackage

// File: rtl/processor_gen2_if.sv
// processor_gen2 memory bus
// master = cpu side, slave = memory side
interface processor_gen2_if #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 8
);
    logic [1:0]        rwToMem;
    logic [ADDR_W-1:0] addrToMem;
    logic [WORD_W-1:0] dataToMem;
    logic              rdEn;
    logic              wtEn;
    logic [WORD_W-1:0] dataFromMem;

    modport master (
        output rwToMem, addrToMem, dataToMem,
        input  rdEn, wtEn, dataFromMem
    );

    modport slave (
        input  rwToMem, addrToMem, dataToMem,
        output rdEn, wtEn, dataFromMem
    );
endinterface

// File: rtl/processor_gen2_regfile.sv
// processor_gen2 register file
// one write port, datapath and debug async read ports
module processor_gen2_regfile #(
    parameter int WORD_W = 8,
    parameter int REG_N  = 4,
    parameter int REG_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_W-1:0]  waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [REG_W-1:0]  raddr,
    output logic [WORD_W-1:0] rdata,
    input  logic [REG_W-1:0]  dbg_addr,
    output logic [WORD_W-1:0] dbg_data
);
    logic [WORD_W-1:0] regs [REG_N];

    // register storage, cleared on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_N; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (int'(waddr) < REG_N)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata    = (int'(raddr) < REG_N) ? regs[raddr] : '0;
    assign dbg_data = (int'(dbg_addr) < REG_N) ? regs[dbg_addr] : '0;
endmodule

// File: rtl/processor_gen2.sv
// processor_gen2 top: FETCH/EXE/MEM/ERR multicycle core
// instruction = {op[2:0], regIdx, imm}
module processor_gen2
    import processor_gen2_pkg::*;
#(
    parameter int WORD_W      = 8,
    parameter int REG_N       = 4,
    parameter int ADDR_W      = 8,
    parameter int PC_W        = 8,
    parameter int MEM_TIMEOUT = 15,
    localparam int REG_W      = (REG_N > 1) ? $clog2(REG_N) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3+REG_W+WORD_W-1:0] instruction,
    output logic [WORD_W-1:0]         data,
    output logic [PC_W-1:0]           pcCounter,
    output logic [1:0]                cpuState,
    output logic [1:0]                errCode,
    output logic                      carry,
    input  logic [REG_W-1:0]          dbgSel,
    output logic [WORD_W-1:0]         dbgData,
    processor_gen2_if.master          mem
);
    localparam int INSTR_W = 3 + REG_W + WORD_W;
    localparam int CNT_W   = $clog2(MEM_TIMEOUT + 1);

    logic [2:0]        op;
    logic [REG_W-1:0]  idx;
    logic [WORD_W-1:0] imm;
    logic [WORD_W-1:0] rd_data;
    logic [WORD_W:0]   sum;
    logic              illegal;
    logic              mem_done;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_nxt;
    logic [1:0]        rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] dout_q;
    logic              we;
    logic [WORD_W-1:0] wdata;

    assign op       = instruction[INSTR_W-1 -: 3];
    assign idx      = instruction[WORD_W +: REG_W];
    assign imm      = instruction[WORD_W-1:0];
    assign sum      = {1'b0, rd_data} + {1'b0, imm};
    assign illegal  = !is_legal_op(op) || (int'(idx) >= REG_N);
    assign mem_done = (rw_q == IO_RD) ? mem.rdEn : mem.wtEn;
    assign wait_nxt = wait_cnt + 1'b1;

    assign mem.rwToMem   = rw_q;
    assign mem.addrToMem = addr_q;
    assign mem.dataToMem = dout_q;

    processor_gen2_regfile #(
        .WORD_W (WORD_W),
        .REG_N  (REG_N),
        .REG_W  (REG_W)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .waddr    (idx),
        .wdata    (wdata),
        .raddr    (idx),
        .rdata    (rd_data),
        .dbg_addr (dbgSel),
        .dbg_data (dbgData)
    );

    // register write: SET/ADD in EXE, LD data on rdEn in MEM
    always_comb begin
        we    = 1'b0;
        wdata = imm;
        if (cpuState == S_EXE && !illegal) begin
            if (op == OP_SET) begin
                we = 1'b1;
            end else if (op == OP_ADD) begin
                we    = 1'b1;
                wdata = sum[WORD_W-1:0];
            end
        end else if (cpuState == S_MEM && rw_q == IO_RD && mem.rdEn) begin
            we    = 1'b1;
            wdata = mem.dataFromMem;
        end
    end

    // control state, PC, result/flag registers and memory request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpuState  <= S_FETCH;
            pcCounter <= '0;
            data      <= '0;
            carry     <= 1'b0;
            errCode   <= ERR_NONE;
            wait_cnt  <= '0;
            rw_q      <= IO_IDLE;
            addr_q    <= '0;
            dout_q    <= '0;
        end else begin
            unique case (1'b1)
                (cpuState == S_FETCH): begin
                    rw_q     <= IO_IDLE;
                    cpuState <= S_EXE;
                end
                (cpuState == S_EXE): begin
                    if (illegal) begin
                        cpuState <= S_ERR;
                        errCode  <= ERR_ILLEGAL;
                    end else begin
                        cpuState <= S_FETCH;
                        case (op)
                            OP_GET: begin
                                data      <= rd_data;
                                pcCounter <= pcCounter + 1'b1;
                            end
                            OP_ADD: begin
                                carry     <= sum[WORD_W];
                                pcCounter <= pcCounter + 1'b1;
                            end
                            OP_JMP: begin
                                pcCounter <= PC_W'(imm);
                            end
                            OP_LD: begin
                                cpuState <= S_MEM;
                                rw_q     <= IO_RD;
                                addr_q   <= ADDR_W'(imm);
                                wait_cnt <= '0;
                            end
                            OP_ST: begin
                                cpuState <= S_MEM;
                                rw_q     <= IO_WT;
                                addr_q   <= ADDR_W'(imm);
                                dout_q   <= rd_data;
                                wait_cnt <= '0;
                            end
                            default: begin
                                pcCounter <= pcCounter + 1'b1;
                            end
                        endcase
                    end
                end
                (cpuState == S_MEM): begin
                    if (mem_done) begin
                        rw_q      <= IO_IDLE;
                        pcCounter <= pcCounter + 1'b1;
                        cpuState  <= S_FETCH;
                    end else if (wait_nxt == CNT_W'(MEM_TIMEOUT)) begin
                        wait_cnt <= wait_nxt;
                        rw_q     <= IO_IDLE;
                        errCode  <= ERR_TIMEOUT;
                        cpuState <= S_ERR;
                    end else begin
                        wait_cnt <= wait_nxt;
                    end
                end
                (cpuState == S_ERR): begin
                    rw_q <= IO_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_processor_gen2.sv
// processor_gen2 directed testbench
// hand-computed vectors, memory side driven by the bench
module tb_processor_gen2;
    import processor_gen2_pkg::*;

    logic        clk;
    logic        reset;
    logic [12:0] instruction;
    logic [7:0]  data;
    logic [7:0]  pcCounter;
    logic [1:0]  cpuState;
    logic [1:0]  errCode;
    logic        carry;
    logic [1:0]  dbgSel;
    logic [7:0]  dbgData;

    int checks;
    int errors;

    processor_gen2_if #(.WORD_W(8), .ADDR_W(8)) mem_bus ();

    processor_gen2 dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .data        (data),
        .pcCounter   (pcCounter),
        .cpuState    (cpuState),
        .errCode     (errCode),
        .carry       (carry),
        .dbgSel      (dbgSel),
        .dbgData     (dbgData),
        .mem         (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] ins(input logic [2:0] op,
                                        input logic [1:0] r,
                                        input logic [7:0] imm);
        return {op, r, imm};
    endfunction

    task automatic reg_is(input string tag, input logic [1:0] r,
                          input logic [7:0] exp);
        dbgSel = r;
        #0;
        check(tag, dbgData, exp);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        dbgSel  = '0;
        instruction         = ins(OP_NOP, 2'd0, 8'h00);
        mem_bus.rdEn        = 1'b0;
        mem_bus.wtEn        = 1'b0;
        mem_bus.dataFromMem = '0;
        tick(2);

        check("rst_state", cpuState, 0);
        check("rst_pc", pcCounter, 0);
        check("rst_data", data, 0);
        check("rst_rw", mem_bus.rwToMem, 0);
        check("rst_addr", mem_bus.addrToMem, 0);
        check("rst_dout", mem_bus.dataToMem, 0);
        check("rst_carry", carry, 0);
        check("rst_err", errCode, 0);
        reg_is("rst_r0", 2'd0, 8'h00);

        reset = 1'b1;
        instruction = ins(OP_SET, 2'd1, 8'h5A);
        tick(1);
        check("fetch_to_exe", cpuState, 1);
        tick(1);
        check("set_pc", pcCounter, 1);
        instruction = ins(OP_GET, 2'd1, 8'h00);
        tick(2);
        check("get_data", data, 8'h5A);
        check("get_pc", pcCounter, 2);
        check("get_state", cpuState, 0);

        instruction = ins(OP_SET, 2'd0, 8'hF0);
        tick(2);
        instruction = ins(OP_ADD, 2'd0, 8'h20);
        tick(2);
        reg_is("add_r0", 2'd0, 8'h10);
        check("add_carry", carry, 1);
        check("add_pc", pcCounter, 4);
        instruction = ins(OP_ADD, 2'd0, 8'h05);
        tick(2);
        reg_is("add2_r0", 2'd0, 8'h15);
        check("add2_carry", carry, 0);
        check("get_hold", data, 8'h5A);

        instruction = ins(OP_SET, 2'd2, 8'hA7);
        tick(2);
        instruction = ins(OP_ST, 2'd2, 8'h33);
        tick(2);
        for (int i = 0; i < 3; i++) begin
            check("st_wait_rw", mem_bus.rwToMem, IO_WT);
            check("st_wait_addr", mem_bus.addrToMem, 8'h33);
            tick(1);
        end
        check("st_rw4", mem_bus.rwToMem, IO_WT);
        check("st_dout", mem_bus.dataToMem, 8'hA7);
        check("st_pc_hold", pcCounter, 6);
        mem_bus.wtEn = 1'b1;
        tick(1);
        mem_bus.wtEn = 1'b0;
        check("st_done_rw", mem_bus.rwToMem, IO_IDLE);
        check("st_done_pc", pcCounter, 7);
        check("st_done_state", cpuState, 0);

        instruction = ins(OP_LD, 2'd3, 8'h10);
        tick(2);
        check("ld_rw", mem_bus.rwToMem, IO_RD);
        check("ld_addr", mem_bus.addrToMem, 8'h10);
        mem_bus.rdEn = 1'b1;
        mem_bus.dataFromMem = 8'h3C;
        tick(1);
        mem_bus.rdEn = 1'b0;
        reg_is("ld_r3", 2'd3, 8'h3C);
        check("ld_pc", pcCounter, 8);

        instruction = ins(OP_LD, 2'd1, 8'h44);
        tick(2);
        tick(14);
        check("ldlate_state", cpuState, 2);
        mem_bus.rdEn = 1'b1;
        mem_bus.dataFromMem = 8'h99;
        tick(1);
        mem_bus.rdEn = 1'b0;
        check("ldlate_state2", cpuState, 0);
        check("ldlate_err", errCode, 0);
        reg_is("ldlate_r1", 2'd1, 8'h99);
        check("ldlate_pc", pcCounter, 9);

        instruction = ins(OP_LD, 2'd3, 8'h10);
        mem_bus.dataFromMem = 8'hEE;
        tick(2);
        tick(14);
        check("to_still_mem", cpuState, 2);
        tick(1);
        check("to_state", cpuState, 3);
        check("to_err", errCode, 2);
        check("to_rw", mem_bus.rwToMem, IO_IDLE);
        reg_is("to_r3", 2'd3, 8'h3C);
        check("to_pc", pcCounter, 9);
        tick(3);
        check("err_sticky", cpuState, 3);
        check("err_pc_hold", pcCounter, 9);

        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        instruction = ins(OP_ST, 2'd0, 8'h55);
        tick(2);
        check("st2_rw", mem_bus.rwToMem, IO_WT);
        #2;
        reset = 1'b0;
        #1;
        check("midmem_rw", mem_bus.rwToMem, IO_IDLE);
        check("midmem_addr", mem_bus.addrToMem, 0);
        check("midmem_state", cpuState, 0);
        tick(1);
        reset = 1'b1;

        instruction = ins(OP_SET, 2'd2, 8'h11);
        tick(2);
        instruction = ins(OP_ILL, 2'd2, 8'h22);
        tick(2);
        check("ill_state", cpuState, 3);
        check("ill_err", errCode, 1);
        check("ill_pc", pcCounter, 1);
        reg_is("ill_r2", 2'd2, 8'h11);
        #2;
        reset = 1'b0;
        #1;
        check("rst2_state", cpuState, 0);
        check("rst2_err", errCode, 0);
        check("rst2_pc", pcCounter, 0);
        check("rst2_data", data, 0);
        check("rst2_carry", carry, 0);
        reg_is("rst2_r2", 2'd2, 8'h00);
        tick(1);
        reset = 1'b1;

        instruction = ins(OP_JMP, 2'd0, 8'hFF);
        tick(2);
        check("jmp_pc", pcCounter, 8'hFF);
        instruction = ins(OP_NOP, 2'd0, 8'h00);
        tick(2);
        check("wrap_pc", pcCounter, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
